// File: rtl/chunk_feeder.sv
// chunk_feeder: serves one NU-lane row/vector chunk per request from a synchronous memory.
// Build option: define CHUNK_FEEDER_PAD_EN to force lanes past element N-1 to zero.
module chunk_feeder #(
   parameter int NUMBER_OF_EQUATIONS_PER_CLUSTER = 16,
   parameter int ELEMENT_WIDTH                   = 32,
   parameter int NO_OF_UNITS                     = 8
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 start,
   input  logic                                 chunk_req,
   output logic                                 mem_rd_en,
   output logic [31:0]                          mem_addr,
   input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] mem_row_data,
   input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] mem_vec_data,
   output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] row_chunk,
   output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] vec_chunk,
   output logic                                 chunk_valid,
   output logic [31:0]                          chunk_index,
   output logic                                 last_chunk,
   output logic                                 done,
   output logic                                 overrun
);
   localparam int N          = NUMBER_OF_EQUATIONS_PER_CLUSTER;
   localparam int EW         = ELEMENT_WIDTH;
   localparam int NU         = NO_OF_UNITS;
   localparam int ADDITIONAL = NU - (N % NU);
   localparam int TOTAL      = N + ADDITIONAL;
   localparam int NUM_CHUNKS = TOTAL / NU;
   localparam logic [31:0] LAST_INDEX = 32'(NUM_CHUNKS - 1);

   typedef enum logic [1:0] {IDLE, READ, CAPTURE, DONE} state_t;

   state_t           state_reg;
   state_t           state_next;
   logic [31:0]      index_reg;
   logic             is_last;
   logic             busy;
   logic             capture;
   logic [EW*NU-1:0] row_lanes;
   logic [EW*NU-1:0] vec_lanes;

   assign is_last = (index_reg == LAST_INDEX);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // start has priority over everything, including a read already issued
   always_comb begin
      state_next = state_reg;
      if (start) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE:    if (chunk_req) state_next = READ;
            READ:    state_next = CAPTURE;
            CAPTURE: state_next = is_last ? DONE : IDLE;
            DONE:    state_next = DONE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      mem_rd_en = 1'b0;
      mem_addr  = '0;
      busy      = 1'b0;
      capture   = 1'b0;
      case (state_reg)
         READ: begin
            mem_rd_en = 1'b1;
            mem_addr  = index_reg;
            busy      = 1'b1;
         end
         CAPTURE: begin
            busy    = 1'b1;
            capture = 1'b1;
         end
         default: ;
      endcase
   end

`ifdef CHUNK_FEEDER_PAD_EN
   logic [31:0] base_elem;
   assign base_elem = index_reg * 32'(NU);
`endif

   for (genvar gi = 0; gi < NU; gi++) begin : g_lane
`ifdef CHUNK_FEEDER_PAD_EN
      logic pad;
      assign pad = (base_elem + 32'(gi)) >= 32'(N);
      assign row_lanes[EW*gi +: EW] = pad ? {EW{1'b0}} : mem_row_data[EW*gi +: EW];
      assign vec_lanes[EW*gi +: EW] = pad ? {EW{1'b0}} : mem_vec_data[EW*gi +: EW];
`else
      assign row_lanes[EW*gi +: EW] = mem_row_data[EW*gi +: EW];
      assign vec_lanes[EW*gi +: EW] = mem_vec_data[EW*gi +: EW];
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         index_reg   <= '0;
         row_chunk   <= '0;
         vec_chunk   <= '0;
         chunk_valid <= 1'b0;
         chunk_index <= '0;
         last_chunk  <= 1'b0;
         done        <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         chunk_valid <= 1'b0;
         last_chunk  <= 1'b0;
         if (start) begin
            index_reg <= '0;
            done      <= 1'b0;
            overrun   <= 1'b0;
         end else begin
            if (chunk_req && busy) overrun <= 1'b1;
            if (capture) begin
               row_chunk   <= row_lanes;
               vec_chunk   <= vec_lanes;
               chunk_valid <= 1'b1;
               chunk_index <= index_reg;
               last_chunk  <= is_last;
               index_reg   <= index_reg + 32'd1;
               if (is_last) done <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_chunk_feeder.sv
// Bench for chunk_feeder: two instances (N=16 and N=12, NU=8) on shared stimulus,
// checked every cycle against a transaction-level model plus directed literal checks.
`timescale 1ns/1ps
module tb_chunk_feeder;
   localparam int NU = 8;
   localparam int EW = 32;
   localparam int DW = NU * EW;
`ifdef CHUNK_FEEDER_PAD_EN
   localparam bit PAD = 1'b1;
`else
   localparam bit PAD = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset, start, chunk_req;
   bit   all_ones = 1'b0;

   logic          rd_en [2];
   logic [31:0]   addr  [2];
   logic [DW-1:0] rowd  [2];
   logic [DW-1:0] vecd  [2];
   logic [DW-1:0] rowc  [2];
   logic [DW-1:0] vecc  [2];
   logic          cv    [2];
   logic [31:0]   cidx  [2];
   logic          lastc [2];
   logic          dn    [2];
   logic          ovr   [2];

   logic [31:0] row_mem [32];
   logic [31:0] vec_mem [32];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   chunk_feeder #(.NUMBER_OF_EQUATIONS_PER_CLUSTER(16), .ELEMENT_WIDTH(EW), .NO_OF_UNITS(NU)) dut16 (
      .clk(clk), .reset(reset), .start(start), .chunk_req(chunk_req),
      .mem_rd_en(rd_en[0]), .mem_addr(addr[0]), .mem_row_data(rowd[0]), .mem_vec_data(vecd[0]),
      .row_chunk(rowc[0]), .vec_chunk(vecc[0]), .chunk_valid(cv[0]), .chunk_index(cidx[0]),
      .last_chunk(lastc[0]), .done(dn[0]), .overrun(ovr[0]));

   chunk_feeder #(.NUMBER_OF_EQUATIONS_PER_CLUSTER(12), .ELEMENT_WIDTH(EW), .NO_OF_UNITS(NU)) dut12 (
      .clk(clk), .reset(reset), .start(start), .chunk_req(chunk_req),
      .mem_rd_en(rd_en[1]), .mem_addr(addr[1]), .mem_row_data(rowd[1]), .mem_vec_data(vecd[1]),
      .row_chunk(rowc[1]), .vec_chunk(vecc[1]), .chunk_valid(cv[1]), .chunk_index(cidx[1]),
      .last_chunk(lastc[1]), .done(dn[1]), .overrun(ovr[1]));

   function automatic int n_of(input int i);
      return (i == 0) ? 16 : 12;
   endfunction

   // one extra chunk is always appended, even when N divides evenly
   function automatic int nc_of(input int n);
      return n / NU + 1;
   endfunction

   function automatic logic [31:0] mem_word(input int e, input bit is_vec);
      if (all_ones) return 32'hFFFF_FFFF;
      return is_vec ? vec_mem[e % 32] : row_mem[e % 32];
   endfunction

   function automatic logic [DW-1:0] mem_lanes(input logic [31:0] a, input bit is_vec);
      logic [DW-1:0] d;
      for (int k = 0; k < NU; k++) d[k*EW +: EW] = mem_word(int'(a) * NU + k, is_vec);
      return d;
   endfunction

   function automatic logic [DW-1:0] junk();
      logic [DW-1:0] d;
      for (int k = 0; k < NU; k++) d[k*EW +: EW] = $urandom();
      return d;
   endfunction

   function automatic logic [DW-1:0] exp_lanes(input int idx, input int n, input bit is_vec);
      logic [DW-1:0] d;
      int e;
      for (int k = 0; k < NU; k++) begin
         e = idx * NU + k;
         d[k*EW +: EW] = (PAD && e >= n) ? 32'h0 : mem_word(e, is_vec);
      end
      return d;
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
      end
   endtask

   // synchronous memory: data for the address read appears the following cycle, junk otherwise
   initial begin
      forever begin
         @(posedge clk);
         for (int i = 0; i < 2; i++) begin
            if (rd_en[i] === 1'b1) begin
               rowd[i] <= mem_lanes(addr[i], 1'b0);
               vecd[i] <= mem_lanes(addr[i], 1'b1);
            end else begin
               rowd[i] <= junk();
               vecd[i] <= junk();
            end
         end
      end
   end

   // transaction model: an accepted request yields its chunk two edges later
   bit            model_ok = 1'b0;
   int            m_idx  [2];
   int            m_pend [2];
   bit            m_done [2];
   bit            m_ovr  [2];
   bit            m_valid[2];
   bit            m_last [2];
   logic [31:0]   m_cidx [2];
   logic [DW-1:0] m_row  [2];
   logic [DW-1:0] m_vec  [2];
   logic [DW-1:0] m_nrow [2];
   logic [DW-1:0] m_nvec [2];

   initial begin
      forever begin
         @(posedge clk);
         for (int i = 0; i < 2; i++) begin
            m_valid[i] = 1'b0;
            m_last[i]  = 1'b0;
            if (reset) begin
               m_idx[i] = 0; m_pend[i] = 0; m_done[i] = 1'b0; m_ovr[i] = 1'b0;
               m_cidx[i] = '0; m_row[i] = '0; m_vec[i] = '0;
               model_ok = 1'b1;
            end else if (start) begin
               m_idx[i] = 0; m_pend[i] = 0; m_done[i] = 1'b0; m_ovr[i] = 1'b0;
            end else if (m_pend[i] == 2) begin
               if (chunk_req) m_ovr[i] = 1'b1;
               m_pend[i] = 1;
               m_nrow[i] = exp_lanes(m_idx[i], n_of(i), 1'b0);
               m_nvec[i] = exp_lanes(m_idx[i], n_of(i), 1'b1);
            end else if (m_pend[i] == 1) begin
               if (chunk_req) m_ovr[i] = 1'b1;
               m_pend[i]  = 0;
               m_valid[i] = 1'b1;
               m_cidx[i]  = 32'(m_idx[i]);
               m_row[i]   = m_nrow[i];
               m_vec[i]   = m_nvec[i];
               m_last[i]  = (m_idx[i] == nc_of(n_of(i)) - 1);
               if (m_last[i]) m_done[i] = 1'b1;
               m_idx[i]++;
            end else if (chunk_req && !m_done[i]) begin
               m_pend[i] = 2;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (model_ok) begin
            for (int i = 0; i < 2; i++) begin
               chk($sformatf("i%0d_rd_en", i), DW'(rd_en[i]), DW'(m_pend[i] == 2));
               if (m_pend[i] == 2) chk($sformatf("i%0d_addr", i), DW'(addr[i]), DW'(32'(m_idx[i])));
               chk($sformatf("i%0d_valid", i), DW'(cv[i]), DW'(m_valid[i]));
               chk($sformatf("i%0d_index", i), DW'(cidx[i]), DW'(m_cidx[i]));
               chk($sformatf("i%0d_last", i), DW'(lastc[i]), DW'(m_last[i]));
               chk($sformatf("i%0d_done", i), DW'(dn[i]), DW'(m_done[i]));
               chk($sformatf("i%0d_overrun", i), DW'(ovr[i]), DW'(m_ovr[i]));
               chk($sformatf("i%0d_row", i), rowc[i], m_row[i]);
               chk($sformatf("i%0d_vec", i), vecc[i], m_vec[i]);
               if (cv[i] === 1'b1)
                  $display("chunk inst=%0d index=%0d last=%0b done=%0b row=%h", i, cidx[i], lastc[i], dn[i], rowc[i]);
            end
         end
      end
   end

   task automatic step(input logic r, input logic s, input logic q);
      reset = r; start = s; chunk_req = q;
      @(posedge clk);
      @(negedge clk);
   endtask

   logic [DW-1:0] exp_w;

   initial begin
      reset = 1'b1; start = 1'b0; chunk_req = 1'b0;
      for (int e = 0; e < 32; e++) begin
         row_mem[e] = $urandom();
         vec_mem[e] = $urandom();
      end
      repeat (3) step(1'b1, 1'b0, 1'b0);
      chk("rst_valid", DW'(cv[0]), DW'(1'b0));
      chk("rst_rd_en", DW'(rd_en[0]), DW'(1'b0));
      chk("rst_addr", DW'(addr[0]), DW'(32'd0));
      chk("rst_index", DW'(cidx[0]), DW'(32'd0));
      chk("rst_flags", DW'({lastc[0], dn[0], ovr[0]}), DW'(3'b000));
      chk("rst_row", rowc[0], '0);
      step(1'b0, 1'b0, 1'b0);

      // three spaced requests on the N=16 instance
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b0, 1'b1);
         chk("s1_rd_en", DW'(rd_en[0]), DW'(1'b1));
         chk("s1_addr", DW'(addr[0]), DW'(32'(k)));
         step(1'b0, 1'b0, 1'b0);
         chk("s1_valid_early", DW'(cv[0]), DW'(1'b0));
         step(1'b0, 1'b0, 1'b0);
         chk("s1_valid", DW'(cv[0]), DW'(1'b1));
         chk("s1_index", DW'(cidx[0]), DW'(32'(k)));
         chk("s1_last", DW'(lastc[0]), DW'(k == 2));
         chk("s1_done", DW'(dn[0]), DW'(k == 2));
         step(1'b0, 1'b0, 1'b0);
         step(1'b0, 1'b0, 1'b0);
      end
      for (int k = 0; k < NU; k++) exp_w[k*EW +: EW] = PAD ? 32'h0 : row_mem[16 + k];
      chk("s1_chunk2_row", rowc[0], exp_w);

      // all-ones memory: N=12 chunk 1 keeps only lanes 0-3 when padding
      all_ones = 1'b1;
      step(1'b0, 1'b1, 1'b0);
      chk("s2_start_done", DW'(dn[0]), DW'(1'b0));
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b0, 1'b1);
         step(1'b0, 1'b0, 1'b0);
         step(1'b0, 1'b0, 1'b0);
         if (k == 1) begin
            for (int l = 0; l < NU; l++) exp_w[l*EW +: EW] = (l < 4 || !PAD) ? 32'hFFFF_FFFF : 32'h0;
            chk("s2_row_pad", rowc[1], exp_w);
            chk("s2_vec_pad", vecc[1], exp_w);
         end
         step(1'b0, 1'b0, 1'b0);
      end
      chk("s2_done16", DW'(dn[0]), DW'(1'b1));
      chk("s2_done12", DW'(dn[1]), DW'(1'b1));

      // request while done is ignored without overrun; start re-arms at chunk 0
      step(1'b0, 1'b0, 1'b1);
      chk("s3_rd_en_done", DW'({rd_en[1], rd_en[0]}), DW'(2'b00));
      step(1'b0, 1'b0, 1'b0);
      chk("s3_overrun", DW'({ovr[1], ovr[0]}), DW'(2'b00));
      step(1'b0, 1'b1, 1'b0);
      chk("s3_done_clr", DW'({dn[1], dn[0]}), DW'(2'b00));
      step(1'b0, 1'b0, 1'b1);
      chk("s3_rd_en", DW'(rd_en[0]), DW'(1'b1));
      chk("s3_addr", DW'(addr[0]), DW'(32'd0));
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk("s3_index", DW'(cidx[0]), DW'(32'd0));
      all_ones = 1'b0;

      // requests held through the busy cycles
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      chk("s4_valid", DW'(cv[0]), DW'(1'b1));
      chk("s4_index", DW'(cidx[0]), DW'(32'd1));
      chk("s4_overrun", DW'(ovr[0]), DW'(1'b1));
      step(1'b0, 1'b0, 1'b0);
      chk("s4_no_extra", DW'({cv[0], rd_en[0]}), DW'(2'b00));
      step(1'b0, 1'b0, 1'b1);
      chk("s4_addr", DW'(addr[0]), DW'(32'd2));
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk("s4_index2", DW'(cidx[0]), DW'(32'd2));

      // reset while a read is in flight
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      chk("s5_addr_pre", DW'(addr[0]), DW'(32'd1));
      step(1'b1, 1'b0, 1'b0);
      chk("s5_flags", DW'({cv[0], rd_en[0], lastc[0], dn[0], ovr[0]}), DW'(5'b0));
      chk("s5_row", rowc[0], '0);
      chk("s5_vec", vecc[0], '0);
      chk("s5_index", DW'(cidx[0]), DW'(32'd0));
      step(1'b0, 1'b0, 1'b0);
      chk("s5_no_valid", DW'(cv[0]), DW'(1'b0));
      step(1'b0, 1'b0, 1'b1);
      chk("s5_addr", DW'(addr[0]), DW'(32'd0));
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);

      // start and request together: start wins
      step(1'b0, 1'b1, 1'b1);
      chk("s6_rd_en_a", DW'(rd_en[0]), DW'(1'b0));
      step(1'b0, 1'b0, 1'b0);
      chk("s6_rd_en_b", DW'(rd_en[0]), DW'(1'b0));

      // randomized traffic
      for (int c = 0; c < 1200; c++) begin
         if (c % 64 == 0) all_ones = ($urandom_range(0, 3) == 0);
         step(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 40));
      end
      repeat (4) step(1'b0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
